// File: rtl/multadd_lanes.sv
// multadd_lanes: unsigned sum of LANES products with 1- or 2-cycle latency per op,
// optional running accumulation and a sticky carry-out flag.
module multadd_lanes #(
   parameter  int WIDTH     = 8,
   parameter  int LANES     = 2,
   parameter  int ACC_GUARD = 0,
   localparam int OUT_W     = 2*WIDTH + $clog2(LANES) + ACC_GUARD
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   input  logic                   pipeline,
   input  logic                   acc_en,
   output logic [OUT_W-1:0]       prodsum,
   output logic                   prodout,
   output logic                   ovf
);
   logic                 s1_valid_q, s1_acc_q, prodout_q, ovf_q, ovf_d;
   logic                 accept, retire, acc_ret;
   logic [OUT_W-1:0]     prodsum_q, prodsum_d, p_now, p_s1, p_ret;
   logic [OUT_W:0]       sum;
   logic [2*WIDTH-1:0]   s1_prod_q [LANES];
   logic [2*WIDTH-1:0]   s1_prod_d [LANES];

   // An occupied stage 1 retires next edge, so only another pipelined op may enter now
   assign in_ready = rst & (~s1_valid_q | pipeline);
   assign accept   = in_valid & in_ready;
   assign retire   = s1_valid_q | (accept & ~pipeline);

   always_comb begin
      p_now = '0;
      p_s1  = '0;
      for (int i = 0; i < LANES; i++) begin
         s1_prod_d[i] = (2*WIDTH)'(a[i*WIDTH +: WIDTH]) * (2*WIDTH)'(b[i*WIDTH +: WIDTH]);
         p_now += OUT_W'(s1_prod_d[i]);
         p_s1  += OUT_W'(s1_prod_q[i]);
      end
   end

   assign acc_ret   = s1_valid_q ? s1_acc_q : acc_en;
   assign p_ret     = s1_valid_q ? p_s1 : p_now;
   assign sum       = {1'b0, p_ret} + {1'b0, acc_ret ? prodsum_q : OUT_W'(0)};
   assign prodsum_d = retire ? sum[OUT_W-1:0] : prodsum_q;
   assign ovf_d     = retire ? acc_ret & (ovf_q | sum[OUT_W]) : ovf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_acc_q   <= 1'b0;
         s1_prod_q  <= '{default: '0};
         prodsum_q  <= '0;
         prodout_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         s1_valid_q <= accept & pipeline;
         s1_acc_q   <= acc_en;
         s1_prod_q  <= s1_prod_d;
         prodsum_q  <= prodsum_d;
         prodout_q  <= retire;
         ovf_q      <= ovf_d;
      end
   end

   assign prodsum = prodsum_q;
   assign prodout = prodout_q;
   assign ovf     = ovf_q;
endmodule

// File: doc/multadd_lanes.md
# multadd_lanes

Parametrised multiply-add engine: the next generation of the fixed 8-bit, two-product multadd unit. It computes the unsigned sum of LANES products a[i]*b[i], with run-time selectable single-cycle or two-stage pipelined latency and an optional running accumulation. It uses a valid/ready input handshake and emits a one-cycle result strobe. It sits as a datapath leaf under the DSP subsystem and is driven by the UVM multadd agent.

## Interface
- WIDTH, 8: operand width in bits
- LANES, 2: number of product lanes (≥1)
- ACC_GUARD, 0: extra accumulator guard bits
- OUT_W, 2*WIDTH + $clog2(LANES) + ACC_GUARD: result width (derived, not overridden; default gives 17)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set presented
- in_ready  out  1  engine can accept; transfer when in_valid && in_ready
- a  in  LANES*WIDTH  packed operands, lane i at [i*WIDTH +: WIDTH]
- b  in  LANES*WIDTH  packed operands, same packing
- pipeline  in  1  per-transaction mode: 0 = 1-cycle latency, 1 = 2-cycle latency
- acc_en  in  1  per-transaction: 1 = add to running accumulator, 0 = start fresh
- prodsum  out  OUT_W  registered result
- prodout  out  1  one-cycle strobe: prodsum valid
- ovf  out  1  sticky carry-out of the accumulation chain, registered with prodsum

## Operation
- All arithmetic is unsigned. The product sum P = Σ a[i]*b[i] always fits in OUT_W without wrap.
- Result R = P + (acc_en ? prodsum_prev : 0), taken mod 2^OUT_W. prodsum_prev is the last value on prodsum, i.e. the running accumulator.
- pipeline=0: at the accept edge, R is computed combinationally and registered into prodsum.
- pipeline=1: at the accept edge, the LANES products plus acc_en are registered into stage 1. At the next edge, the sum and accumulate step registers into prodsum.
- pipeline and acc_en are sampled at accept and travel with the transaction.
- Accumulation uses prodsum at the retire edge, so back-to-back accumulating ops chain correctly in either mode.
- ovf is updated on every retire:
  - acc_en=0: cleared.
  - acc_en=1: ovf_prev OR carry-out of P + prodsum_prev.
- Collision rule: in the cycle after a pipeline=1 accept, stage 1 is occupied. In that cycle in_ready = pipeline, so only another pipeline=1 op may be accepted. This is combinational from the pipeline input.
- Outside that case, in_ready = 1 whenever out of reset. Full throughput is one op per cycle within a single mode.
- prodsum holds its value between strobes.
- Reset (rst low, asynchronous):
  - prodsum=0, prodout=0, ovf=0, stage 1 invalid, in_ready=0.
  - In-flight transactions are discarded, and no prodout is generated for them after release.
  - The first accept is possible in the first cycle with rst high.

## Timing
- Accept in cycle t with pipeline=0: prodout=1 in cycle t+1.
- Accept in cycle t with pipeline=1: prodout=1 in cycle t+2.
- prodout is high for exactly one cycle per accepted transaction. Results retire in accept order and are never dropped or merged.
- Mode switch 1→0 costs one bubble cycle (in_ready low). Switch 0→1 costs none.
- A retire and a new accept in the same cycle are legal. A pipeline=0 accept in cycle t while a pipeline=1 op retires in t is allowed.
- No combinational path from a, b, or acc_en to any output. Only pipeline→in_ready is combinational.

## Test plan
- **Single-cycle:** WIDTH=8, LANES=2, a={5,3}, b={6,4}, pipeline=0, acc_en=0, accept at t → prodsum=42, prodout=1 at t+1 only, ovf=0.
- **Pipelined back-to-back:**
  - Stimulus: pipeline=1 ops {1,1}·{2,2}=4 and {10,10}·{10,10}=200, accepted t and t+1.
  - Response: prodout at t+2 (4) and t+3 (200); in_ready stays 1.
- **Accumulate wrap:**
  - Stimulus: a=b={255,255}, first op acc_en=0, second acc_en=1.
  - Response: first prodsum=130050, ovf=0; then prodsum=129028 (260100 mod 131072), ovf=1.
  - A following acc_en=0 op clears ovf.
- **Mode collision:**
  - Stimulus: pipeline=1 accepted at t; at t+1 present pipeline=0 op.
  - Response: in_ready=0 at t+1; the op is accepted at t+2 and retires at t+3. The pipeline=1 result retires at t+2 with no lost or merged strobe.
- **Reset mid-flight:**
  - Stimulus: pipeline=1 op accepted; rst low for a partial cycle before its retire.
  - Response: outputs go to 0 immediately. No prodout after release. A post-reset op with acc_en=1 and P=7 gives prodsum=7.
- **Parametrised:**
  - Stimulus: WIDTH=16, LANES=4, ACC_GUARD=4 (OUT_W=38); all lanes 65535, acc_en=0.
  - Response: prodsum=17179344900, ovf=0, latency per mode as above.
